// File: rtl/mult_div_seq.sv
// Sequential 32-bit multiply/divide unit (MULT, MULTU, DIV, DIVU) with HI/LO result registers.
// One shift-add or restoring shift-subtract step per cycle over a 64-bit accumulator.
module mult_div_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {StIdle, StPrep, StRun, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        dz_q, dz_d;

  logic        is_div, is_signed;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [33:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  // Datapath helpers: operand magnitudes, one iteration step, and final sign correction.
  always_comb begin
    abs_a = a_q;
    abs_b = b_q;
    if (is_signed && a_q[31]) abs_a = 32'd0 - a_q;
    if (is_signed && b_q[31]) abs_b = 32'd0 - b_q;

    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    // Partial remainder shifted left by one with the next dividend bit, minus divisor.
    div_diff = {1'b0, acc_q[63:31]} - {2'b00, opnd_q};

    prod_fix = acc_q;
    quo_fix  = acc_q[31:0];
    rem_fix  = acc_q[63:32];
    if (neg_res_q) begin
      prod_fix = 64'd0 - acc_q;
      quo_fix  = 32'd0 - acc_q[31:0];
    end
    if (neg_rem_q) rem_fix = 32'd0 - acc_q[63:32];
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          dz_d    = 1'b0;
          state_d = StPrep;
        end
      end
      StPrep: begin
        cnt_d     = 5'd0;
        neg_res_d = is_signed & (a_q[31] ^ b_q[31]);
        neg_rem_d = is_signed & a_q[31];
        if (is_div) begin
          opnd_d = abs_b;
          acc_d  = {32'd0, abs_a};
        end else begin
          opnd_d = abs_a;
          acc_d  = {32'd0, abs_b};
        end
        if (is_div && (b_q == 32'd0)) begin
          dz_d    = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (is_div) begin
          if (!div_diff[33]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
          else               acc_d = {acc_q[62:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StFix;
      end
      StFix: begin
        if (is_div) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= 2'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      opnd_q    <= 32'd0;
      acc_q     <= 64'd0;
      cnt_q     <= 5'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dz_q      <= dz_d;
    end
  end

  assign busy     = (state_q == StPrep) || (state_q == StRun) || (state_q == StFix);
  assign done     = (state_q == StDone);
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
